mem_stage_ctrl: RTL
===================

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL take parameter ACK_TIMEOUT, default 16: maximum cycles spent waiting for dmem_ack before an access is aborted (legal range 2..255).
REQ-002 SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock, rising edge; reset  in  1  asynchronous, active-low.
- mem_read_in, mem_write_in  in  1  load/store flags from the EX-to-MEM register.
- branch_eq_in, branch_ne_in, zero_in  in  1  branch flags and ALU zero from the EX-to-MEM register.
- alu_result_in  in  32  effective address; write_data_in  in  32  store data; pc_branch_in  in  32  branch target.
- dmem_req  out  1  request; dmem_we  out  1  write enable; dmem_addr  out  32; dmem_wdata  out  32.
- dmem_ack  in  1  access complete; dmem_rdata  in  32  load data, valid with dmem_ack.
- stall  out  1  freeze PC and all upstream pipeline registers.
- pc_src  out  1  take branch; pc_branch_out  out  32  target; flush  out  1  squash IF/ID and ID/EX.
- read_data_out  out  32  load result; read_valid  out  1  read_data_out valid.
- bus_err  out  1  one-cycle pulse on a timed-out or rejected access.

Function
REQ-003 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-004 IDLE: if mem_read_in or mem_write_in, SHALL latch address, data and write flag, then go to ACCESS next cycle; otherwise stay.
REQ-005 ACCESS: dmem_req=1; dmem_we, dmem_addr and dmem_wdata SHALL hold latched values and stay stable until ack or abort.
REQ-006 ACCESS: on dmem_ack, SHALL capture dmem_rdata for a load (0 for a store) and go to DONE.
REQ-007 ACCESS: a wait counter SHALL count cycles in ACCESS; at ACK_TIMEOUT cycles without ack, SHALL go to DONE with read_data_out=0 and pulse bus_err.
REQ-008 Ack in the same cycle the timeout expires SHALL count as success: no bus_err, data captured.
REQ-009 DONE: read_valid=1 for exactly one cycle if the access was a load; SHALL go to IDLE unconditionally, ignoring still-asserted mem_read_in/mem_write_in.
REQ-010 stall SHALL equal (IDLE and (mem_read_in or mem_write_in)) or ACCESS; it is combinational and low in DONE.
REQ-011 Latency: a load with ack on the first ACCESS cycle SHALL produce read_valid 2 cycles after it appears in IDLE.
REQ-012 pc_src SHALL equal (branch_eq_in and zero_in) or (branch_ne_in and not zero_in), combinationally; flush=pc_src; pc_branch_out=pc_branch_in.
REQ-013 dmem_ack outside ACCESS SHALL be ignored.
REQ-014 read_data_out SHALL hold its last value until the next completed access.

Reset
REQ-015 reset low SHALL force IDLE immediately, clear the wait counter, and zero all registered outputs: dmem_req, dmem_we, dmem_addr, dmem_wdata, read_data_out, read_valid, bus_err.
REQ-016 Reset during ACCESS SHALL drop dmem_req asynchronously; the aborted access SHALL produce no read_valid or bus_err.

Configuration
REQ-017 With MEM_ALIGN_CHECK_EN defined, an access with alu_result_in[1:0] != 0 SHALL skip ACCESS, go IDLE->DONE, keep dmem_req low and pulse bus_err.
REQ-018 Without MEM_ALIGN_CHECK_EN, SHALL issue all addresses unchanged, with no alignment logic.

Structure
REQ-019 The FSM state encoding typedef and the default ACK_TIMEOUT constant SHALL live in the shared pipeline package.
REQ-020 Branch resolution SHALL be a sub-module, branch_resolve, that is purely combinational; the FSM and counter stay in mem_stage_ctrl.

Verification
REQ-021 The bench SHALL cover these scenarios, one per line: stimulus -> required response.
- Load at 0x0000_0010, ack on the first ACCESS cycle with rdata 0xDEADBEEF -> stall high 2 cycles, read_valid pulses with 0xDEADBEEF.
- Store of 0x1234_5678 to 0x20, ack after 5 cycles -> dmem_we=1, addr and wdata stable throughout, no read_valid, stall high 6 cycles.
- Load with no ack, ACK_TIMEOUT=16 -> dmem_req high 16 cycles, bus_err pulses once, read_data_out=0.
- branch_eq_in=1, zero_in=1, pc_branch_in=0x40 -> pc_src=1, flush=1, pc_branch_out=0x40; with zero_in=0 -> pc_src=0; branch_ne_in mirrors this.
- reset asserted on the 3rd ACCESS cycle -> dmem_req=0 immediately, state IDLE, all outputs 0, no bus_err.
- MEM_ALIGN_CHECK_EN defined, load from 0x13 -> dmem_req never high, bus_err pulses once, stall high 1 cycle.

Source files
------------

// File: rtl/mem_stage_ctrl_pkg.sv
// Shared pipeline package: MEM-stage FSM state encoding and default ack timeout.
package mem_stage_ctrl_pkg;

  localparam int unsigned AckTimeoutDefault = 16;
  localparam int unsigned WaitCntW          = 8;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/response bus between the MEM stage (master) and memory (slave).
interface mem_stage_ctrl_if;

  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );

endinterface

// File: rtl/mem_stage_ctrl_branch_resolve.sv
// Combinational branch decision from EX/MEM branch flags and the ALU zero flag.
module branch_resolve (
  input  logic branch_eq,
  input  logic branch_ne,
  input  logic zero,
  output logic take
);

  assign take = (branch_eq & zero) | (branch_ne & ~zero);

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: data-memory access FSM with ack timeout, stall and branch resolve.
// Optional MEM_ALIGN_CHECK_EN rejects word-misaligned accesses without touching the bus.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = AckTimeoutDefault
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_read_in,
  input  logic                    mem_write_in,
  input  logic                    branch_eq_in,
  input  logic                    branch_ne_in,
  input  logic                    zero_in,
  input  logic [31:0]             alu_result_in,
  input  logic [31:0]             write_data_in,
  input  logic [31:0]             pc_branch_in,
  mem_stage_ctrl_if.master        dmem,
  output logic                    stall,
  output logic                    pc_src,
  output logic [31:0]             pc_branch_out,
  output logic                    flush,
  output logic [31:0]             read_data_out,
  output logic                    read_valid,
  output logic                    bus_err
);

  mem_state_e          state_q, state_d;
  logic [WaitCntW-1:0] wait_q, wait_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic                err_q, err_d;
  logic                access;
  logic                wait_last;

  assign access    = mem_read_in | mem_write_in;
  assign wait_last = (wait_q == WaitCntW'(ACK_TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    stall    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (access) begin
          stall   = 1'b1;
          we_d    = mem_write_in;
          addr_d  = alu_result_in;
          wdata_d = write_data_in;
          wait_d  = '0;
`ifdef MEM_ALIGN_CHECK_EN
          if (alu_result_in[1:0] != 2'b00) begin
            state_d  = StDone;
            rdata_d  = '0;
            rvalid_d = ~mem_write_in;
            err_d    = 1'b1;
          end else begin
            state_d = StAccess;
            req_d   = 1'b1;
          end
`else
          state_d = StAccess;
          req_d   = 1'b1;
`endif
        end
      end
      StAccess: begin
        stall = 1'b1;
        // An ack coinciding with the last wait cycle wins over the timeout.
        if (dmem.ack) begin
          state_d  = StDone;
          req_d    = 1'b0;
          rdata_d  = we_q ? 32'h0 : dmem.rdata;
          rvalid_d = ~we_q;
        end else if (wait_last) begin
          state_d  = StDone;
          req_d    = 1'b0;
          rdata_d  = '0;
          rvalid_d = ~we_q;
          err_d    = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        wait_d  = '0;
      end
      default: begin
        state_d = StIdle;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      wait_q   <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  assign dmem.req      = req_q;
  assign dmem.we       = we_q;
  assign dmem.addr     = addr_q;
  assign dmem.wdata    = wdata_q;
  assign read_data_out = rdata_q;
  assign read_valid    = rvalid_q;
  assign bus_err       = err_q;

  branch_resolve u_branch_resolve (
    .branch_eq (branch_eq_in),
    .branch_ne (branch_ne_in),
    .zero      (zero_in),
    .take      (pc_src)
  );

  assign flush         = pc_src;
  assign pc_branch_out = pc_branch_in;

endmodule
